// File: rtl/mux16_scan_pkg.sv
// +--------------------------------------------------------------------+
// | mux16_scan_pkg : shared widths and FSM encoding for the scanner     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package mux16_scan_pkg;

  localparam int N_CH     = 16;
  localparam int SEL_W    = 4;
  localparam int SETTLE_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mux16_next_chan.sv
// +--------------------------------------------------------------------+
// | mux16_next_chan : lowest enabled channel above i_sel (or overall)   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mux16_next_chan
  import mux16_scan_pkg::*;
(
  input  logic [N_CH-1:0]  i_mask,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_first,
  output logic [SEL_W-1:0] o_chan,
  output logic             o_found
);

  // Descending walk so the last hit, i.e. the lowest qualifying channel, wins.
  always_comb begin
    o_chan  = '0;
    o_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (SEL_W'(i) > i_sel))) begin
        o_chan  = SEL_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux16_scan_ctrl.sv
// +--------------------------------------------------------------------+
// | mux16_scan_ctrl : drives a 16:1 mux select and captures one scan    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mux16_scan_ctrl
  import mux16_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_CH-1:0]  chan_mask,
  input  logic             mux_y,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  data
);

  localparam logic [SETTLE_W-1:0] c_RELOAD = SETTLE_W'(SETTLE - 1);

  state_t               r_state;
  logic [N_CH-1:0]      r_mask;
  logic [N_CH-1:0]      r_shadow;
  logic [N_CH-1:0]      r_data;
  logic [SEL_W-1:0]     r_sel;
  logic [SETTLE_W-1:0]  r_cnt;
  logic                 r_busy;
  logic                 r_done;

  logic [SEL_W-1:0]     w_first_chan;
  logic                 w_first_found;
  logic [SEL_W-1:0]     w_next_chan;
  logic                 w_next_found;
  logic [N_CH-1:0]      w_merged;

  mux16_next_chan u_first (
    .i_mask  (chan_mask),
    .i_sel   ('0),
    .i_first (1'b1),
    .o_chan  (w_first_chan),
    .o_found (w_first_found)
  );

  mux16_next_chan u_next (
    .i_mask  (r_mask),
    .i_sel   (r_sel),
    .i_first (1'b0),
    .o_chan  (w_next_chan),
    .o_found (w_next_found)
  );

  // Final capture word with the bit being sampled this edge folded in.
  always_comb begin
    w_merged        = r_shadow;
    w_merged[r_sel] = mux_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mask   <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_first_found) begin
              r_mask   <= chan_mask;
              r_shadow <= '0;
              r_sel    <= w_first_chan;
              r_cnt    <= c_RELOAD;
              r_busy   <= 1'b1;
              r_state  <= ST_SCAN;
            end else begin
              r_data <= '0;
              r_done <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shadow[r_sel] <= mux_y;
            if (w_next_found) begin
              r_sel <= w_next_chan;
              r_cnt <= c_RELOAD;
            end else begin
              r_data  <= w_merged;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel  = r_sel;
  assign busy = r_busy;
  assign done = r_done;
  assign data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_mux16_scan_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_mux16_scan_ctrl : directed bench, SETTLE=1 and SETTLE=3 units    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mux16_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] mask = '0;
  logic [15:0] pat1 = '0;
  logic [15:0] pat3 = '0;

  logic [3:0]  sel1, sel3;
  logic        busy1, busy3, done1, done3;
  logic [15:0] data1, data3;
  logic        y1, y3;

  int checks = 0;
  int errors = 0;
  int cyc;

  assign y1 = pat1[sel1];
  assign y3 = pat3[sel3];

  always #5 clk = ~clk;

  mux16_scan_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .chan_mask(mask),
    .mux_y(y1), .sel(sel1), .busy(busy1), .done(done1), .data(data1)
  );

  mux16_scan_ctrl #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .chan_mask(mask),
    .mux_y(y3), .sel(sel3), .busy(busy3), .done(done3), .data(data3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps until done1 is seen or the limit expires; returns edges elapsed.
  task automatic wait_done1(input int limit, output int n);
    n = 0;
    while (!done1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start1 = 1'($urandom); start3 = 1'($urandom); abort = 1'($urandom);
      mask = 16'($urandom);
      tick();
    end
    chk("rst_sel1", 32'(sel1), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_done1", 32'(done1), 0);
    chk("rst_data1", 32'(data1), 0);
    chk("rst_sel3", 32'(sel3), 0);
    chk("rst_busy3", 32'(busy3), 0);
    chk("rst_done3", 32'(done3), 0);
    chk("rst_data3", 32'(data3), 0);
    start1 = 0; start3 = 0; abort = 0; mask = '0;
    rst_n = 1'b1;
    tick();

    // Full scan, SETTLE=1
    pat1 = 16'hA5C3; mask = 16'hFFFF; start1 = 1;
    tick();
    start1 = 0;
    chk("full_sel0", 32'(sel1), 0);
    chk("full_busy0", 32'(busy1), 1);
    for (int j = 1; j < 16; j++) begin
      tick();
      chk("full_sel", 32'(sel1), 32'(j));
      chk("full_busy", 32'(busy1), 1);
      chk("full_nodone", 32'(done1), 0);
    end
    tick();
    chk("full_done", 32'(done1), 1);
    chk("full_busy_end", 32'(busy1), 0);
    chk("full_data", 32'(data1), 32'h0000A5C3);
    tick();
    chk("full_done_pulse", 32'(done1), 0);
    chk("full_sel_hold", 32'(sel1), 15);

    // Sparse scan, SETTLE=3
    pat3 = 16'hFFFF; mask = 16'h8101; start3 = 1;
    tick();
    start3 = 0;
    for (int k = 0; k < 9; k++) begin
      chk("sparse_sel", 32'(sel3), (k < 3) ? 0 : (k < 6) ? 8 : 15);
      chk("sparse_busy", 32'(busy3), 1);
      tick();
    end
    chk("sparse_done", 32'(done3), 1);
    chk("sparse_busy_end", 32'(busy3), 0);
    chk("sparse_data", 32'(data3), 32'h00008101);

    // Empty mask
    mask = 16'h0000; start1 = 1;
    tick();
    start1 = 0;
    chk("empty_done", 32'(done1), 1);
    chk("empty_busy", 32'(busy1), 0);
    chk("empty_data", 32'(data1), 0);
    tick();
    chk("empty_done_pulse", 32'(done1), 0);
    chk("empty_busy2", 32'(busy1), 0);

    // Prime data with 1234, then abort after the 5th sample
    pat1 = 16'h1234; mask = 16'hFFFF; start1 = 1;
    tick();
    start1 = 0;
    wait_done1(40, cyc);
    chk("prime_len", 32'(cyc), 16);
    chk("prime_data", 32'(data1), 32'h00001234);
    pat1 = 16'hFFFF; start1 = 1;
    tick();
    start1 = 0;
    for (int i = 0; i < 5; i++) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_done", 32'(done1), 0);
    chk("abort_data", 32'(data1), 32'h00001234);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_nodone", 32'(done1), 0);
    end
    start1 = 1;
    tick();
    start1 = 0;
    wait_done1(40, cyc);
    chk("after_abort_len", 32'(cyc), 16);
    chk("after_abort_data", 32'(data1), 32'h0000FFFF);

    // start pulses during SCAN are ignored
    pat1 = 16'h5A0F; start1 = 1;
    tick();
    start1 = 0;
    for (int i = 0; i < 3; i++) tick();
    start1 = 1;
    tick(); tick();
    start1 = 0;
    wait_done1(40, cyc);
    chk("ign_start_len", 32'(cyc + 5), 16);
    chk("ign_start_data", 32'(data1), 32'h00005A0F);

    // start+abort in IDLE is a start
    tick();
    pat1 = 16'h0F0F; start1 = 1; abort = 1;
    tick();
    start1 = 0; abort = 0;
    chk("sa_busy", 32'(busy1), 1);
    chk("sa_sel", 32'(sel1), 0);
    wait_done1(40, cyc);
    chk("sa_len", 32'(cyc), 16);
    chk("sa_data", 32'(data1), 32'h00000F0F);

    // Reset mid-scan discards everything
    start1 = 1;
    tick();
    start1 = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midrst_sel", 32'(sel1), 0);
    chk("midrst_busy", 32'(busy1), 0);
    chk("midrst_data", 32'(data1), 0);
    chk("midrst_done", 32'(done1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
